uart_receiver: RTL and testbench

- Receive-side counterpart of the existing 8N1 transmitter (same ClkFrequency/Baud defaults: 12 MHz, 115200).
- Consumes the serial line from PMOD (or the transmitter's TxD in loopback) and produces 8-bit bytes with a one-cycle valid strobe and a framing-error strobe.
- Sits directly downstream of the serial pin, upstream of any command/FIFO logic.

---
 rtl/uart_receiver.sv | 198 +++++++++++++++++++
 tb/tb_uart_receiver.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : 8N1 UART receiver. Oversamples the serial line on a tick
//               derived from the system clock, majority-filters three
//               consecutive samples, and delivers bytes (LSB first on the
//               line) with a one-cycle ready strobe or a one-cycle framing
//               error strobe.
// Ports       : clk             - system clock
//               rst_n           - asynchronous active-low reset
//               RxD             - serial line, idle high, asynchronous
//               RxD_data        - last correctly received byte
//               RxD_data_ready  - 1-clk pulse, RxD_data valid from here on
//               RxD_frame_error - 1-clk pulse, stop bit sampled low
//               RxD_idle        - high while the receiver is idle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver #(
    parameter int CLK_FREQUENCY = 12000000,
    parameter int BAUD          = 115200,
    parameter int OVERSAMPLING  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       RxD_frame_error,
    output logic       RxD_idle
);

    // Clocks per oversampling tick, rounded to nearest.
    localparam int c_DIV = (CLK_FREQUENCY + BAUD * OVERSAMPLING / 2) / (BAUD * OVERSAMPLING);
    localparam int c_TW  = (c_DIV > 2) ? $clog2(c_DIV) : 1;
    localparam int c_OSW = (OVERSAMPLING > 2) ? $clog2(OVERSAMPLING) : 1;

    if (c_DIV < 2) begin : g_bad_div
        $error("uart_receiver: clocks per tick must be at least 2");
    end

    if ((OVERSAMPLING < 4) || (OVERSAMPLING > 16) ||
        ((OVERSAMPLING & (OVERSAMPLING - 1)) != 0)) begin : g_bad_os
        $error("uart_receiver: OVERSAMPLING must be a power of two in 4..16");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    logic [1:0]       r_sync;
    logic [2:0]       r_taps;
    logic [c_TW-1:0]  r_tick_cnt;
    logic             w_tick;
    logic             w_filt;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [c_OSW-1:0] r_os_cnt;
    logic [c_OSW-1:0] w_os_nxt;
    logic [2:0]       r_bit_cnt;
    logic [2:0]       w_bit_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             w_os_last;
    logic             w_os_half;
    logic             w_done;
    logic             w_ferr;

    logic [7:0]       r_data;
    logic             r_ready;
    logic             r_ferr;

    assign w_tick    = (r_tick_cnt == c_TW'(c_DIV - 1));
    assign w_filt    = (r_taps[0] & r_taps[1]) | (r_taps[0] & r_taps[2]) | (r_taps[1] & r_taps[2]);
    assign w_os_last = (r_os_cnt == c_OSW'(OVERSAMPLING - 1));
    assign w_os_half = (r_os_cnt == c_OSW'(OVERSAMPLING / 2 - 1));

    // Synchronizer, free-running tick divider and majority tap register.
    // Reset values are all-ones so a released reset looks like an idle line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync     <= 2'b11;
            r_taps     <= 3'b111;
            r_tick_cnt <= '0;
        end else begin
            r_sync <= {r_sync[0], RxD};
            if (w_tick) begin
                r_tick_cnt <= '0;
                r_taps     <= {r_taps[1:0], r_sync[1]};
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end
        end
    end

    // Next-state logic; everything advances only on tick cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_os_nxt    = r_os_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_done      = 1'b0;
        w_ferr      = 1'b0;
        if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_filt) begin
                        w_state_nxt = S_START;
                        w_os_nxt    = '0;
                    end
                end
                S_START: begin
                    // Re-check the line half a bit in to reject glitches.
                    if (w_os_half) begin
                        if (!w_filt) begin
                            w_state_nxt = S_DATA;
                            w_os_nxt    = '0;
                            w_bit_nxt   = '0;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_os_nxt = r_os_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_os_last) begin
                        w_os_nxt    = '0;
                        w_shift_nxt = {w_filt, r_shift[7:1]};
                        w_bit_nxt   = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_state_nxt = S_STOP;
                        end
                    end else begin
                        w_os_nxt = r_os_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_os_last) begin
                        w_os_nxt = '0;
                        if (w_filt) begin
                            w_done      = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_ferr      = 1'b1;
                            w_state_nxt = S_BREAK;
                        end
                    end else begin
                        w_os_nxt = r_os_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    // Wait for the line to recover so a held-low line
                    // is not decoded as an endless run of frames.
                    if (w_filt) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_os_cnt  <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_ready   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_os_cnt  <= w_os_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_ready   <= w_done;
            r_ferr    <= w_ferr;
            if (w_done) begin
                r_data <= r_shift;
            end
        end
    end

    assign RxD_data        = r_data;
    assign RxD_data_ready  = r_ready;
    assign RxD_frame_error = r_ferr;
    assign RxD_idle        = (r_state == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_receiver
// Description : Self-checking bench for uart_receiver. Serial frames are
//               driven at a chosen clocks-per-bit; expected bytes go into a
//               queue as they are sent, received bytes are collected from
//               the ready strobe, and each scenario compares the two.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

    logic       clk;
    logic       rst_n;
    logic       RxD;
    logic [7:0] RxD_data;
    logic       RxD_data_ready;
    logic       RxD_frame_error;
    logic       RxD_idle;

    int         checks;
    int         errors;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         ferr_cnt;
    int         both_cnt;
    bit         idle_low_seen;

    uart_receiver dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .RxD             (RxD),
        .RxD_data        (RxD_data),
        .RxD_data_ready  (RxD_data_ready),
        .RxD_frame_error (RxD_frame_error),
        .RxD_idle        (RxD_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hold the line at lvl for nclk clocks, observing outputs each falling edge.
    task automatic line(input logic lvl, input int nclk);
        for (int i = 0; i < nclk; i++) begin
            @(negedge clk);
            if (RxD_data_ready) rx_q.push_back(RxD_data);
            if (RxD_frame_error) ferr_cnt++;
            if (RxD_data_ready && RxD_frame_error) both_cnt++;
            if (!RxD_idle) idle_low_seen = 1'b1;
            RxD = lvl;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int cpb, input logic stop_lvl);
        line(1'b0, cpb);
        for (int i = 0; i < 8; i++) line(b[i], cpb);
        line(stop_lvl, cpb);
    endtask

    task automatic clear_obs();
        exp_q.delete();
        rx_q.delete();
        ferr_cnt      = 0;
        both_cnt      = 0;
        idle_low_seen = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        RxD   = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (RxD_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", RxD_data); end
        checks++; if (RxD_data_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", RxD_data_ready); end
        checks++; if (RxD_frame_error !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", RxD_frame_error); end
        checks++; if (RxD_idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", RxD_idle); end
        rst_n = 1'b1;
        line(1'b1, 208);
    endtask

    task automatic test_single();
        logic [7:0] e, r;
        clear_obs();
        line(1'b1, 208);
        exp_q.push_back(8'h61);
        send_byte(8'h61, 104, 1'b1);
        line(1'b1, 208);
        checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL single_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); r = rx_q.pop_front();
            checks++; if (r !== e) begin errors++; $display("FAIL single_data: got %h expected %h", r, e); end
        end
        checks++; if (idle_low_seen !== 1'b1) begin errors++; $display("FAIL single_idle_low: got %b expected 1", idle_low_seen); end
        checks++; if (RxD_idle !== 1'b1) begin errors++; $display("FAIL single_idle_after: got %b expected 1", RxD_idle); end
        checks++; if (ferr_cnt != 0) begin errors++; $display("FAIL single_ferr: got %0d expected 0", ferr_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e, r;
        clear_obs();
        exp_q.push_back(8'h00);
        send_byte(8'h00, 104, 1'b1);
        exp_q.push_back(8'hFF);
        send_byte(8'hFF, 104, 1'b1);
        line(1'b1, 208);
        checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); r = rx_q.pop_front();
            checks++; if (r !== e) begin errors++; $display("FAIL b2b_data: got %h expected %h", r, e); end
        end
        checks++; if (ferr_cnt != 0) begin errors++; $display("FAIL b2b_ferr: got %0d expected 0", ferr_cnt); end
    endtask

    task automatic test_false_start();
        clear_obs();
        line(1'b0, 20);
        line(1'b1, 104);
        checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL false_ready: got %0d expected 0", rx_q.size()); end
        checks++; if (ferr_cnt != 0) begin errors++; $display("FAIL false_ferr: got %0d expected 0", ferr_cnt); end
        checks++; if (RxD_idle !== 1'b1) begin errors++; $display("FAIL false_idle: got %b expected 1", RxD_idle); end
        line(1'b1, 104);
    endtask

    task automatic test_frame_error();
        logic [7:0] e, r;
        clear_obs();
        // Previous received byte was 0xFF and must survive the bad frame.
        send_byte(8'h55, 104, 1'b0);
        line(1'b0, 3 * 10 * 104);
        checks++; if (ferr_cnt != 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", ferr_cnt); end
        checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL ferr_ready: got %0d expected 0", rx_q.size()); end
        checks++; if (RxD_data !== 8'hFF) begin errors++; $display("FAIL ferr_data_kept: got %h expected ff", RxD_data); end
        checks++; if (RxD_idle !== 1'b0) begin errors++; $display("FAIL ferr_break_idle: got %b expected 0", RxD_idle); end
        line(1'b1, 208);
        checks++; if (RxD_idle !== 1'b1) begin errors++; $display("FAIL ferr_recover_idle: got %b expected 1", RxD_idle); end
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 104, 1'b1);
        line(1'b1, 208);
        checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL ferr_next_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); r = rx_q.pop_front();
            checks++; if (r !== e) begin errors++; $display("FAIL ferr_next_data: got %h expected %h", r, e); end
        end
        checks++; if (ferr_cnt != 1) begin errors++; $display("FAIL ferr_total: got %0d expected 1", ferr_cnt); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b, e, r;
        clear_obs();
        b = 8'h3C;
        line(1'b0, 104);
        for (int i = 0; i < 3; i++) line(b[i], 104);
        line(b[3], 52);
        rst_n = 1'b0;
        line(b[3], 5);
        rst_n = 1'b1;
        // The aborted frame is abandoned; the line returns to idle.
        line(1'b1, 3 * 104);
        checks++; if (RxD_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h expected 00", RxD_data); end
        checks++; if (RxD_idle !== 1'b1) begin errors++; $display("FAIL rstmid_idle: got %b expected 1", RxD_idle); end
        checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL rstmid_no_strobe: got %0d expected 0", rx_q.size()); end
        exp_q.push_back(8'hC3);
        send_byte(8'hC3, 104, 1'b1);
        line(1'b1, 208);
        checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); r = rx_q.pop_front();
            checks++; if (r !== e) begin errors++; $display("FAIL rstmid_data_rx: got %h expected %h", r, e); end
        end
        checks++; if (ferr_cnt != 0) begin errors++; $display("FAIL rstmid_ferr: got %0d expected 0", ferr_cnt); end
    endtask

    task automatic test_loopback();
        int         cpbs[3];
        logic [7:0] e, r;
        cpbs = '{104, 101, 107};
        foreach (cpbs[k]) begin
            clear_obs();
            line(1'b1, 2 * cpbs[k]);
            for (int n = 0; n < 6; n++) begin
                exp_q.push_back(8'h61);
                send_byte(8'h61, cpbs[k], 1'b1);
            end
            line(1'b1, 2 * cpbs[k]);
            checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL loop_count cpb=%0d: got %0d expected %0d", cpbs[k], rx_q.size(), exp_q.size()); end
            while (exp_q.size() > 0 && rx_q.size() > 0) begin
                e = exp_q.pop_front(); r = rx_q.pop_front();
                checks++; if (r !== e) begin errors++; $display("FAIL loop_data cpb=%0d: got %h expected %h", cpbs[k], r, e); end
            end
            checks++; if (ferr_cnt != 0) begin errors++; $display("FAIL loop_ferr cpb=%0d: got %0d expected 0", cpbs[k], ferr_cnt); end
            checks++; if (both_cnt != 0) begin errors++; $display("FAIL loop_overlap cpb=%0d: got %0d expected 0", cpbs[k], both_cnt); end
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        ferr_cnt      = 0;
        both_cnt      = 0;
        idle_low_seen = 1'b0;
        rst_n         = 1'b0;
        RxD           = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_false_start();
        test_frame_error();
        test_reset_midframe();
        test_loopback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
